// File: rtl/ex_stage_if.sv
// Execute-stage bus: forwarding selects, operands and MDU commands in; result, store data and MDU status out.
// The hazard side consumes MDU_Stall; the pipeline holds EX inputs while it is high.
interface ex_stage_if;
  logic [1:0]  EX_ForwardA;
  logic [1:0]  EX_ForwardB;
  logic [31:0] EX_RsData;
  logic [31:0] EX_RtData;
  logic [31:0] MEM_ALUOut;
  logic [31:0] WB_WriteData;
  logic [31:0] EX_Imm;
  logic        EX_ALUSrc;
  logic [3:0]  EX_ALUCtl;
  logic [4:0]  EX_Shamt;
  logic [2:0]  EX_MDOp;
  logic [1:0]  EX_MDRead;
  logic        EX_Hold;
  logic [31:0] EX_Result;
  logic [31:0] EX_StoreData;
  logic        MDU_Busy;
  logic        MDU_Stall;

  modport master (
    output EX_ForwardA, EX_ForwardB, EX_RsData, EX_RtData, MEM_ALUOut, WB_WriteData,
           EX_Imm, EX_ALUSrc, EX_ALUCtl, EX_Shamt, EX_MDOp, EX_MDRead, EX_Hold,
    input  EX_Result, EX_StoreData, MDU_Busy, MDU_Stall
  );

  modport slave (
    input  EX_ForwardA, EX_ForwardB, EX_RsData, EX_RtData, MEM_ALUOut, WB_WriteData,
           EX_Imm, EX_ALUSrc, EX_ALUCtl, EX_Shamt, EX_MDOp, EX_MDRead, EX_Hold,
    output EX_Result, EX_StoreData, MDU_Busy, MDU_Stall
  );
endinterface

// File: rtl/ex_stage.sv
// MIPS execute stage: forwarded operands, zero-latency ALU, 32-cycle iterative mult/div with HI/LO.
// Stalls (MDU_Stall) any MDU command or HI/LO read that arrives while the MDU is iterating.
module ex_stage (
  input  logic      clk,
  input  logic      reset,
  ex_stage_if.slave ex
);
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  typedef enum logic {IDLE, RUN} mdu_state_t;

  function automatic logic [31:0] fwd_sel(input logic [1:0] sel, input logic [31:0] rf,
                                          input logic [31:0] mem, input logic [31:0] wb);
    case (sel)
      2'b10:   return mem;
      2'b01:   return wb;
      default: return rf;
    endcase
  endfunction

  logic [31:0] op_a, fwd_b, op_b, alu_out;

  assign op_a  = fwd_sel(ex.EX_ForwardA, ex.EX_RsData, ex.MEM_ALUOut, ex.WB_WriteData);
  assign fwd_b = fwd_sel(ex.EX_ForwardB, ex.EX_RtData, ex.MEM_ALUOut, ex.WB_WriteData);
  assign op_b  = ex.EX_ALUSrc ? ex.EX_Imm : fwd_b;

  always_comb begin
    alu_out = '0;
    case (ex.EX_ALUCtl)
      4'b0000: alu_out = op_a & op_b;
      4'b0001: alu_out = op_a | op_b;
      4'b0010: alu_out = op_a + op_b;
      4'b0011: alu_out = op_a ^ op_b;
      4'b0100: alu_out = ~(op_a | op_b);
      4'b0110: alu_out = op_a - op_b;
      4'b0111: alu_out = {31'd0, $signed(op_a) < $signed(op_b)};
      4'b1000: alu_out = {31'd0, op_a < op_b};
      4'b1001: alu_out = op_b << ex.EX_Shamt;
      4'b1010: alu_out = op_b >> ex.EX_Shamt;
      4'b1011: alu_out = $unsigned($signed(op_b) >>> ex.EX_Shamt);
      4'b1100: alu_out = {op_b[15:0], 16'd0};
      default: alu_out = '0;
    endcase
  end

  mdu_state_t  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] p_hi_q, p_hi_d, p_lo_q, p_lo_d, b_q, b_d, dividend_q, dividend_d;
  logic        is_div_q, is_div_d, neg_q_q, neg_q_d, neg_r_q, neg_r_d, div_zero_q, div_zero_d;

  logic [32:0] mul_sum, div_shift;
  logic [31:0] div_diff, step_hi, step_lo, quo, rem;
  logic [63:0] prod;
  logic        div_ge, sgn_op, sa, sb;

  // One iteration: multiply shifts {carry,hi,lo} right; restoring divide shifts {hi,lo} left.
  always_comb begin
    mul_sum   = {1'b0, p_hi_q} + (p_lo_q[0] ? {1'b0, b_q} : 33'd0);
    div_shift = {p_hi_q, p_lo_q[31]};
    div_ge    = div_shift >= {1'b0, b_q};
    div_diff  = div_shift[31:0] - b_q;
    if (is_div_q) begin
      step_hi = div_ge ? div_diff : div_shift[31:0];
      step_lo = {p_lo_q[30:0], div_ge};
    end else begin
      step_hi = mul_sum[32:1];
      step_lo = {mul_sum[0], p_lo_q[31:1]};
    end
    prod = neg_q_q ? -{step_hi, step_lo} : {step_hi, step_lo};
    quo  = neg_q_q ? -step_lo : step_lo;
    rem  = neg_r_q ? -step_hi : step_hi;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    p_hi_d     = p_hi_q;
    p_lo_d     = p_lo_q;
    b_d        = b_q;
    dividend_d = dividend_q;
    is_div_d   = is_div_q;
    neg_q_d    = neg_q_q;
    neg_r_d    = neg_r_q;
    div_zero_d = div_zero_q;
    sgn_op     = (ex.EX_MDOp == MD_MULT) || (ex.EX_MDOp == MD_DIV);
    sa         = sgn_op && op_a[31];
    sb         = sgn_op && fwd_b[31];
    case (state_q)
      IDLE: begin
        if (!ex.EX_Hold) begin
          case (ex.EX_MDOp)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
              state_d    = RUN;
              cnt_d      = '0;
              p_hi_d     = '0;
              p_lo_d     = sa ? -op_a : op_a;
              b_d        = sb ? -fwd_b : fwd_b;
              dividend_d = op_a;
              is_div_d   = (ex.EX_MDOp == MD_DIV) || (ex.EX_MDOp == MD_DIVU);
              neg_q_d    = sa ^ sb;
              neg_r_d    = sa;
              div_zero_d = (fwd_b == '0);
            end
            MD_MTHI: hi_d = op_a;
            MD_MTLO: lo_d = op_a;
            default: ;
          endcase
        end
      end
      RUN: begin
        p_hi_d = step_hi;
        p_lo_d = step_lo;
        cnt_d  = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = IDLE;
          if (!is_div_q) begin
            hi_d = prod[63:32];
            lo_d = prod[31:0];
          end else if (div_zero_q) begin
            hi_d = dividend_q;
            lo_d = 32'hFFFF_FFFF;
          end else begin
            hi_d = rem;
            lo_d = quo;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      p_hi_q     <= '0;
      p_lo_q     <= '0;
      b_q        <= '0;
      dividend_q <= '0;
      is_div_q   <= 1'b0;
      neg_q_q    <= 1'b0;
      neg_r_q    <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      p_hi_q     <= p_hi_d;
      p_lo_q     <= p_lo_d;
      b_q        <= b_d;
      dividend_q <= dividend_d;
      is_div_q   <= is_div_d;
      neg_q_q    <= neg_q_d;
      neg_r_q    <= neg_r_d;
      div_zero_q <= div_zero_d;
    end
  end

  logic md_cmd, md_read;
  // Encodings 111 (MDOp) and 11 (MDRead) behave as "none", so they never stall.
  assign md_cmd  = (ex.EX_MDOp != 3'b000) && (ex.EX_MDOp != 3'b111);
  assign md_read = (ex.EX_MDRead == 2'b01) || (ex.EX_MDRead == 2'b10);

  assign ex.MDU_Busy     = (state_q == RUN);
  assign ex.MDU_Stall    = ex.MDU_Busy && (md_cmd || md_read);
  assign ex.EX_StoreData = fwd_b;
  assign ex.EX_Result    = (ex.EX_MDRead == 2'b01) ? hi_q :
                           (ex.EX_MDRead == 2'b10) ? lo_q : alu_out;
endmodule
